axil_cmd_seq: RTL and testbench
===============================

Name: axil_cmd_seq

Overview:
- AXI-lite master sequencer that sits directly upstream of i2c_master_axil and drives its 4-bit register space.
- Accepts a stream of commands: WRITE, READ, or POLL until masked match.
- Issues single AXI-lite transactions, one at a time.
- Returns exactly one response per command, so firmware or a boot ROM can script I2C transfers without a CPU.

Parameters:
- ADDR_WIDTH, 4, AXI-lite address width; matches the i2c_master_axil register space.
- POLL_GAP, 16, idle cycles between consecutive POLL reads (1..65535).
- POLL_MAX, 1024, maximum POLL reads before timeout; used only when AXIL_SEQ_POLL_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  0=WRITE, 1=READ, 2=POLL, 3=reserved
- cmd_addr  in  ADDR_WIDTH  register address
- cmd_data  in  32  write data (WRITE) or compare value (POLL)
- cmd_mask  in  32  POLL compare mask
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_data  out  32  read data; 0 for WRITE
- rsp_err  out  1  bresp/rresp != 0, reserved op, or timeout
- rsp_timeout  out  1  POLL exhausted POLL_MAX
- busy  out  1  state != IDLE
- m_axil_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready: AXI-lite write channels, master side; widths ADDR_WIDTH/3/1/1, 32/4/1/1, 2/1/1.
- m_axil_araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: AXI-lite read channels, master side; widths ADDR_WIDTH/3/1/1, 32/2/1/1.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All valid/ready outputs 0, except cmd_ready = 1 after reset release.
  - rsp_* = 0, busy = 0, address/data outputs 0.
  - Any outstanding AXI transaction is abandoned; the slave is reset by the same reset.
- Fixed outputs: awprot = arprot = 3'b000; wstrb = 4'hF always.
- cmd_ready = 1 only in IDLE. The command is registered on accept; the first AXI valid rises the next cycle.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, POLL_GAP_WAIT, RSP.
- IDLE, on accept:
  - op 0 → WR_REQ
  - op 1 or 2 → RD_REQ (poll counter cleared)
  - op 3 → RSP with rsp_err = 1; no AXI traffic.
- WR_REQ:
  - awvalid and wvalid rise together.
  - Each drops independently after its own handshake.
  - Once both handshakes are complete → WR_RESP.
- WR_RESP: bready = 1. On bvalid → RSP with rsp_data = 0 and rsp_err = (bresp != 0).
- RD_REQ: arvalid held until arready → RD_RESP.
- RD_RESP: rready = 1. On rvalid, rdata is captured.
  - READ → RSP with rsp_err = (rresp != 0).
  - POLL:
    - rresp != 0 → RSP with err = 1.
    - ((rdata ^ cmd_data) & cmd_mask) == 0 → RSP, success.
    - Otherwise increment the counter → POLL_GAP_WAIT.
- POLL_GAP_WAIT: count POLL_GAP cycles → RD_REQ.
- RSP:
  - rsp_valid held with stable rsp_* until rsp_ready → IDLE.
  - cmd_ready rises the cycle after the response handshake; no command/response overlap.
- Minimum latency, both slave readies high: WRITE accept → rsp_valid = 3 cycles; READ = 3 cycles.
- A mask of 0 matches on the first read.
- Counters saturate and never wrap.

Optional Feature:
- Macro AXIL_SEQ_POLL_TIMEOUT_EN.
- Defined:
  - A 16-bit poll counter is present.
  - After POLL_MAX non-matching reads → RSP with rsp_timeout = 1, rsp_err = 1, rsp_data = last rdata.
- Undefined:
  - No counter; POLL reads indefinitely until a match or an AXI error.
  - rsp_timeout is tied to 0.

Test Plan:
- WRITE addr 0xC data 0x00000031, slave readies always 1 → one AW/W handshake with awaddr = 0xC, wdata = 0x31, wstrb = 0xF; rsp_valid 3 cycles after accept with data 0, err 0.
- WRITE addr 0x4 with awready delayed 3 cycles, wready = 1 → wvalid high 1 cycle, awvalid high 4 cycles, exactly one B; rsp err 0.
- READ addr 0x0, slave returns 0x00000100 with rresp = 2 → rsp_data = 0x100, rsp_err = 1.
- POLL addr 0x0, mask 0x1, data 0x0; slave returns 0x1 three times, then 0x0 → exactly 4 AR handshakes, each spaced ≥ POLL_GAP cycles; rsp_data = 0, err = 0, timeout = 0.
- POLL never matching:
  - POLL_MAX = 4, macro defined → exactly 4 reads, then rsp_timeout = 1, err = 1.
  - Macro undefined → >100 reads and no response.
- Reserved op:
  - op = 3 → rsp err = 1 one cycle after accept; no AXI valid ever asserted.
- Reset mid-operation:
  - rst_n low while in WR_RESP → all valids 0 immediately; after release cmd_ready = 1, busy = 0.

Source files
------------

// File: rtl/axil_cmd_seq.sv
// axil_cmd_seq: command-driven AXI-lite master that scripts WRITE / READ / POLL
// accesses into the i2c_master_axil register space, one transaction at a time,
// with exactly one response per command.
// Optional feature macro: AXIL_SEQ_POLL_TIMEOUT_EN (bounds POLL to POLL_MAX reads).
module axil_cmd_seq #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned POLL_GAP   = 16,
   parameter int unsigned POLL_MAX   = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]           cmd_data,
   input  logic [31:0]           cmd_mask,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_data,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
   output logic [2:0]            m_axil_awprot,
   output logic                  m_axil_awvalid,
   input  logic                  m_axil_awready,
   output logic [31:0]           m_axil_wdata,
   output logic [3:0]            m_axil_wstrb,
   output logic                  m_axil_wvalid,
   input  logic                  m_axil_wready,
   input  logic [1:0]            m_axil_bresp,
   input  logic                  m_axil_bvalid,
   output logic                  m_axil_bready,
   output logic [ADDR_WIDTH-1:0] m_axil_araddr,
   output logic [2:0]            m_axil_arprot,
   output logic                  m_axil_arvalid,
   input  logic                  m_axil_arready,
   input  logic [31:0]           m_axil_rdata,
   input  logic [1:0]            m_axil_rresp,
   input  logic                  m_axil_rvalid,
   output logic                  m_axil_rready
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WR_REQ   = 3'd1;
   localparam logic [2:0] S_WR_RESP  = 3'd2;
   localparam logic [2:0] S_RD_REQ   = 3'd3;
   localparam logic [2:0] S_RD_RESP  = 3'd4;
   localparam logic [2:0] S_GAP_WAIT = 3'd5;
   localparam logic [2:0] S_RSP      = 3'd6;

   localparam logic [1:0]  OP_WRITE = 2'd0;
   localparam logic [1:0]  OP_READ  = 2'd1;
   localparam logic [1:0]  OP_POLL  = 2'd2;
   localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

   logic [2:0]            r_state,     w_state_nxt;
   logic                  r_cmd_ready, w_cmd_ready_nxt;
   logic                  r_busy,      w_busy_nxt;
   logic                  r_rsp_valid, w_rsp_valid_nxt;
   logic [31:0]           r_rsp_data,  w_rsp_data_nxt;
   logic                  r_rsp_err,   w_rsp_err_nxt;
   logic                  r_awvalid,   w_awvalid_nxt;
   logic                  r_wvalid,    w_wvalid_nxt;
   logic                  r_bready,    w_bready_nxt;
   logic                  r_arvalid,   w_arvalid_nxt;
   logic                  r_rready,    w_rready_nxt;
   logic [ADDR_WIDTH-1:0] r_awaddr,    w_awaddr_nxt;
   logic [ADDR_WIDTH-1:0] r_araddr,    w_araddr_nxt;
   logic [31:0]           r_wdata,     w_wdata_nxt;
   logic                  r_is_poll,   w_is_poll_nxt;
   logic [31:0]           r_cmp_data,  w_cmp_data_nxt;
   logic [31:0]           r_cmp_mask,  w_cmp_mask_nxt;
   logic [15:0]           r_gap_cnt,   w_gap_cnt_nxt;
   logic                  w_match;
`ifdef AXIL_SEQ_POLL_TIMEOUT_EN
   localparam logic [15:0] POLL_LAST = 16'(POLL_MAX - 1);
   logic                  r_rsp_timeout, w_rsp_timeout_nxt;
   logic [15:0]           r_poll_cnt,    w_poll_cnt_nxt;
`else
   logic                  w_unused_poll_max;
   assign w_unused_poll_max = ^32'(POLL_MAX);
`endif

   // Masked compare of the returned read data against the POLL target
   assign w_match = ((m_axil_rdata ^ r_cmp_data) & r_cmp_mask) == 32'd0;

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt     = r_state;
      w_rsp_valid_nxt = r_rsp_valid;
      w_rsp_data_nxt  = r_rsp_data;
      w_rsp_err_nxt   = r_rsp_err;
      w_awvalid_nxt   = r_awvalid;
      w_wvalid_nxt    = r_wvalid;
      w_bready_nxt    = r_bready;
      w_arvalid_nxt   = r_arvalid;
      w_rready_nxt    = r_rready;
      w_awaddr_nxt    = r_awaddr;
      w_araddr_nxt    = r_araddr;
      w_wdata_nxt     = r_wdata;
      w_is_poll_nxt   = r_is_poll;
      w_cmp_data_nxt  = r_cmp_data;
      w_cmp_mask_nxt  = r_cmp_mask;
      w_gap_cnt_nxt   = r_gap_cnt;
`ifdef AXIL_SEQ_POLL_TIMEOUT_EN
      w_rsp_timeout_nxt = r_rsp_timeout;
      w_poll_cnt_nxt    = r_poll_cnt;
`endif
      case (r_state)
         S_IDLE: begin
            if (cmd_valid && r_cmd_ready) begin
               w_is_poll_nxt  = (cmd_op == OP_POLL);
               w_cmp_data_nxt = cmd_data;
               w_cmp_mask_nxt = cmd_mask;
               w_rsp_err_nxt  = 1'b0;
               w_rsp_data_nxt = 32'd0;
`ifdef AXIL_SEQ_POLL_TIMEOUT_EN
               w_rsp_timeout_nxt = 1'b0;
               w_poll_cnt_nxt    = 16'd0;
`endif
               if (cmd_op == OP_WRITE) begin
                  w_awaddr_nxt  = cmd_addr;
                  w_wdata_nxt   = cmd_data;
                  w_awvalid_nxt = 1'b1;
                  w_wvalid_nxt  = 1'b1;
                  w_state_nxt   = S_WR_REQ;
               end else if (cmd_op == OP_READ || cmd_op == OP_POLL) begin
                  w_araddr_nxt  = cmd_addr;
                  w_arvalid_nxt = 1'b1;
                  w_state_nxt   = S_RD_REQ;
               end else begin
                  w_rsp_err_nxt   = 1'b1;
                  w_rsp_valid_nxt = 1'b1;
                  w_state_nxt     = S_RSP;
               end
            end
         end
         S_WR_REQ: begin
            if (r_awvalid && m_axil_awready) w_awvalid_nxt = 1'b0;
            if (r_wvalid && m_axil_wready)   w_wvalid_nxt  = 1'b0;
            if (!w_awvalid_nxt && !w_wvalid_nxt) begin
               w_bready_nxt = 1'b1;
               w_state_nxt  = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            if (m_axil_bvalid) begin
               w_bready_nxt    = 1'b0;
               w_rsp_data_nxt  = 32'd0;
               w_rsp_err_nxt   = (m_axil_bresp != 2'b00);
               w_rsp_valid_nxt = 1'b1;
               w_state_nxt     = S_RSP;
            end
         end
         S_RD_REQ: begin
            if (m_axil_arready) begin
               w_arvalid_nxt = 1'b0;
               w_rready_nxt  = 1'b1;
               w_state_nxt   = S_RD_RESP;
            end
         end
         S_RD_RESP: begin
            if (m_axil_rvalid) begin
               w_rready_nxt   = 1'b0;
               w_rsp_data_nxt = m_axil_rdata;
               if (!r_is_poll || m_axil_rresp != 2'b00) begin
                  w_rsp_err_nxt   = (m_axil_rresp != 2'b00);
                  w_rsp_valid_nxt = 1'b1;
                  w_state_nxt     = S_RSP;
               end else if (w_match) begin
                  w_rsp_valid_nxt = 1'b1;
                  w_state_nxt     = S_RSP;
               end else begin
                  w_gap_cnt_nxt = 16'd0;
                  w_state_nxt   = S_GAP_WAIT;
`ifdef AXIL_SEQ_POLL_TIMEOUT_EN
                  if (r_poll_cnt >= POLL_LAST) begin
                     w_rsp_err_nxt     = 1'b1;
                     w_rsp_timeout_nxt = 1'b1;
                     w_rsp_valid_nxt   = 1'b1;
                     w_state_nxt       = S_RSP;
                  end else if (r_poll_cnt != 16'hFFFF) begin
                     w_poll_cnt_nxt = r_poll_cnt + 16'd1;
                  end
`endif
               end
            end
         end
         S_GAP_WAIT: begin
            if (r_gap_cnt >= GAP_LAST) begin
               w_arvalid_nxt = 1'b1;
               w_state_nxt   = S_RD_REQ;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt + 16'd1;
            end
         end
         S_RSP: begin
            if (rsp_ready) begin
               w_rsp_valid_nxt = 1'b0;
               w_state_nxt     = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
      w_busy_nxt      = (w_state_nxt != S_IDLE);
   end

   // State and registered outputs; reset abandons any outstanding transaction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= 32'd0;
         r_rsp_err   <= 1'b0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_awaddr    <= '0;
         r_araddr    <= '0;
         r_wdata     <= 32'd0;
         r_is_poll   <= 1'b0;
         r_cmp_data  <= 32'd0;
         r_cmp_mask  <= 32'd0;
         r_gap_cnt   <= 16'd0;
`ifdef AXIL_SEQ_POLL_TIMEOUT_EN
         r_rsp_timeout <= 1'b0;
         r_poll_cnt    <= 16'd0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_cmd_ready <= w_cmd_ready_nxt;
         r_busy      <= w_busy_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_data  <= w_rsp_data_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_awvalid   <= w_awvalid_nxt;
         r_wvalid    <= w_wvalid_nxt;
         r_bready    <= w_bready_nxt;
         r_arvalid   <= w_arvalid_nxt;
         r_rready    <= w_rready_nxt;
         r_awaddr    <= w_awaddr_nxt;
         r_araddr    <= w_araddr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_is_poll   <= w_is_poll_nxt;
         r_cmp_data  <= w_cmp_data_nxt;
         r_cmp_mask  <= w_cmp_mask_nxt;
         r_gap_cnt   <= w_gap_cnt_nxt;
`ifdef AXIL_SEQ_POLL_TIMEOUT_EN
         r_rsp_timeout <= w_rsp_timeout_nxt;
         r_poll_cnt    <= w_poll_cnt_nxt;
`endif
      end
   end

   assign cmd_ready      = r_cmd_ready;
   assign busy           = r_busy;
   assign rsp_valid      = r_rsp_valid;
   assign rsp_data       = r_rsp_data;
   assign rsp_err        = r_rsp_err;
`ifdef AXIL_SEQ_POLL_TIMEOUT_EN
   assign rsp_timeout    = r_rsp_timeout;
`else
   assign rsp_timeout    = 1'b0;
`endif
   assign m_axil_awaddr  = r_awaddr;
   assign m_axil_awprot  = 3'b000;
   assign m_axil_awvalid = r_awvalid;
   assign m_axil_wdata   = r_wdata;
   assign m_axil_wstrb   = 4'hF;
   assign m_axil_wvalid  = r_wvalid;
   assign m_axil_bready  = r_bready;
   assign m_axil_araddr  = r_araddr;
   assign m_axil_arprot  = 3'b000;
   assign m_axil_arvalid = r_arvalid;
   assign m_axil_rready  = r_rready;

endmodule

// File: tb/tb_axil_cmd_seq.sv
// tb_axil_cmd_seq: directed and randomized checks of axil_cmd_seq against a
// behavioural AXI-lite slave and a command-level reference model.
module tb_axil_cmd_seq;

   localparam int unsigned AW    = 4;
   localparam int unsigned GAP   = 4;
   localparam int unsigned PMAX  = 4;
   localparam int          RSP_LIMIT = 300;
`ifdef AXIL_SEQ_POLL_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk, rst_n;
   logic          cmd_valid, cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_addr;
   logic [31:0]   cmd_data, cmd_mask;
   logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
   logic [31:0]   rsp_data;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;

   axil_cmd_seq #(.ADDR_WIDTH(AW), .POLL_GAP(GAP), .POLL_MAX(PMAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
      .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
      .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
      .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
      .m_axil_bvalid(bvalid), .m_axil_bready(bready),
      .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid),
      .m_axil_arready(arready), .m_axil_rdata(rdata), .m_axil_rresp(rresp),
      .m_axil_rvalid(rvalid), .m_axil_rready(rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Single comparison point: counts every check and reports mismatches
   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- behavioural AXI-lite slave (acts on falling edges) ----
   logic [31:0] mem [16];
   logic [31:0] poll_q [$];
   int aw_lat, w_lat, ar_lat, b_lat;
   logic [1:0] bresp_cfg, rresp_cfg;
   bit aw_got, w_got, ar_got, b_pend, r_pend;
   int aw_wait, w_wait, ar_wait, b_wait;
   int aw_hs, w_hs, b_hs, ar_hs, r_hs, awv_cyc, wv_cyc, any_valid_cyc;
   int cyc, last_ar_cyc, min_ar_gap;
   logic [AW-1:0] cap_awaddr, cap_araddr;
   logic [31:0] cap_wdata;
   logic [3:0]  cap_wstrb;

   task automatic slave_step();
      cyc++;
      if (!rst_n) begin
         awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
         aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
         aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0;
         return;
      end
      if (awvalid) awv_cyc++;
      if (wvalid)  wv_cyc++;
      if (awvalid || wvalid || arvalid) any_valid_cyc++;
      if (b_pend) begin bvalid = 0; b_pend = 0; b_hs++; end
      if (r_pend) begin rvalid = 0; r_pend = 0; r_hs++; end
      if (aw_got && w_got && !bvalid) begin
         if (b_wait >= b_lat) begin
            bvalid = 1; bresp = bresp_cfg; aw_got = 0; w_got = 0; b_wait = 0;
            mem[cap_awaddr] = cap_wdata;
         end else b_wait++;
      end
      if (ar_got && !rvalid) begin
         rvalid = 1; rresp = rresp_cfg; ar_got = 0;
         if (poll_q.size() > 0) rdata = poll_q.pop_front();
         else rdata = mem[cap_araddr];
      end
      awready = 0;
      if (awvalid && !aw_got) begin
         if (aw_wait >= aw_lat) begin
            awready = 1; aw_got = 1; aw_wait = 0; aw_hs++; cap_awaddr = awaddr;
         end else aw_wait++;
      end
      wready = 0;
      if (wvalid && !w_got) begin
         if (w_wait >= w_lat) begin
            wready = 1; w_got = 1; w_wait = 0; w_hs++; cap_wdata = wdata; cap_wstrb = wstrb;
         end else w_wait++;
      end
      arready = 0;
      if (arvalid && !ar_got && !rvalid) begin
         if (ar_wait >= ar_lat) begin
            arready = 1; ar_got = 1; ar_wait = 0; ar_hs++; cap_araddr = araddr;
            if (last_ar_cyc >= 0 && (cyc - last_ar_cyc) < min_ar_gap) min_ar_gap = cyc - last_ar_cyc;
            last_ar_cyc = cyc;
         end else ar_wait++;
      end
      if (bvalid && bready) b_pend = 1;
      if (rvalid && rready) r_pend = 1;
   endtask

   initial begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      aw_lat = 0; w_lat = 0; ar_lat = 0; b_lat = 0; bresp_cfg = 0; rresp_cfg = 0;
      cyc = 0; last_ar_cyc = -1; min_ar_gap = 1000;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      awv_cyc = 0; wv_cyc = 0; any_valid_cyc = 0;
      for (int i = 0; i < 16; i++) mem[i] = 32'd0;
      forever begin
         @(negedge clk);
         slave_step();
      end
   end

   // ---------------- reference model (command level) ----------------------
   logic [31:0] ref_mem [16];

   // POLL outcome from the script of read values; nreads = -1 means no response
   function automatic void poll_model(input logic [31:0] vals[$], input logic [31:0] d,
                                      input logic [31:0] m, input bit rerr, output int nreads,
                                      output logic [31:0] od, output logic oe, output logic ot);
      nreads = 0; od = 0; oe = 0; ot = 0;
      foreach (vals[i]) begin
         nreads++;
         od = vals[i];
         if (rerr) begin oe = 1; return; end
         if (((vals[i] ^ d) & m) == 32'd0) return;
         if (TO_EN && nreads == int'(PMAX)) begin oe = 1; ot = 1; return; end
      end
      nreads = -1;
   endfunction

   // ---------------- command driver ---------------------------------------
   task automatic issue_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                            input logic [31:0] d, input logic [31:0] m);
      int n;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      chk_eq("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      cmd_op = op; cmd_addr = addr; cmd_data = d; cmd_mask = m; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [31:0] d, input logic [31:0] m, input int rdly,
                          output logic [31:0] rd, output logic re, output logic rt,
                          output int lat);
      issue_cmd(op, addr, d, m);
      lat = 1;
      while (!rsp_valid && lat < RSP_LIMIT) begin @(negedge clk); lat++; end
      chk_eq("rsp_seen", 32'(rsp_valid), 32'd1);
      rd = rsp_data; re = rsp_err; rt = rsp_timeout;
      if (rsp_valid) begin
         chk_eq("no_overlap", 32'(cmd_ready), 32'd0);
         chk_eq("busy_in_rsp", 32'(busy), 32'd1);
         for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk_eq("rsp_hold", {rsp_data[31:2], rsp_err, rsp_valid}, {rd[31:2], re, 1'b1});
         end
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         chk_eq("ready_after", 32'(cmd_ready), 32'd1);
         chk_eq("idle_after", 32'({rsp_valid, busy}), 32'd0);
      end
      poll_q.delete();
   endtask

   task automatic reset_dut();
      #2 rst_n = 1'b0;
      #1;
      chk_eq("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, busy, cmd_ready}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk_eq("rst_release", 32'({cmd_ready, busy}), 32'b10);
      poll_q.delete();
   endtask

   // ---------------- stimulus ---------------------------------------------
   initial begin
      logic [31:0] rd, d, m, v, exp_d;
      logic re, rt, exp_e, exp_t;
      logic [1:0] op;
      logic [AW-1:0] a;
      logic [31:0] vals [$];
      int lat, a0, w0, b0, av0, wv0, nv0, nreads, n;

      rst_n = 1'b0; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0; cmd_mask = 0;
      rsp_ready = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;
      #1;
      chk_eq("reset_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, busy, cmd_ready}), 32'd0);
      chk_eq("reset_rsp", {rsp_data[31:1], rsp_err | rsp_timeout}, 32'd0);
      chk_eq("reset_addr", 32'({awaddr, araddr}), 32'd0);
      chk_eq("reset_wdata", wdata, 32'd0);
      chk_eq("fixed_sigs", 32'({awprot, arprot, wstrb}), 32'h00F);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_eq("ready_after_reset", 32'({cmd_ready, busy}), 32'b10);

      // WRITE 0xC <= 0x31, instant slave
      a0 = aw_hs; w0 = w_hs; b0 = b_hs;
      run_cmd(2'd0, 4'hC, 32'h31, 32'h0, 0, rd, re, rt, lat);
      ref_mem[12] = 32'h31;
      chk_eq("wr_lat", 32'(lat), 32'd3);
      chk_eq("wr_rsp", rd, 32'd0);
      chk_eq("wr_err", 32'({re, rt}), 32'd0);
      chk_eq("wr_awaddr", 32'(cap_awaddr), 32'hC);
      chk_eq("wr_wdata", cap_wdata, 32'h31);
      chk_eq("wr_wstrb", 32'(cap_wstrb), 32'hF);
      chk_eq("wr_hs", 32'({8'(aw_hs - a0), 8'(w_hs - w0), 8'(b_hs - b0)}), 32'h010101);

      // WRITE 0x4 with awready delayed 3 cycles
      aw_lat = 3; av0 = awv_cyc; wv0 = wv_cyc; b0 = b_hs;
      run_cmd(2'd0, 4'h4, 32'hA5A5_0004, 32'h0, 1, rd, re, rt, lat);
      ref_mem[4] = 32'hA5A5_0004;
      aw_lat = 0;
      chk_eq("aw_slow_awv", 32'(awv_cyc - av0), 32'd4);
      chk_eq("aw_slow_wv", 32'(wv_cyc - wv0), 32'd1);
      chk_eq("aw_slow_b", 32'(b_hs - b0), 32'd1);
      chk_eq("aw_slow_err", 32'(re), 32'd0);

      // READ returning 0x100 with SLVERR
      rresp_cfg = 2'd2; poll_q.push_back(32'h100); a0 = ar_hs;
      run_cmd(2'd1, 4'h0, 32'h0, 32'h0, 0, rd, re, rt, lat);
      rresp_cfg = 2'd0;
      chk_eq("rd_lat", 32'(lat), 32'd3);
      chk_eq("rd_data", rd, 32'h100);
      chk_eq("rd_err", 32'(re), 32'd1);
      chk_eq("rd_ar", 32'(ar_hs - a0), 32'd1);

      // POLL bit0 == 0: three misses then a hit
      vals = '{32'h1, 32'h1, 32'h1, 32'h0};
      poll_q = vals; a0 = ar_hs; min_ar_gap = 1000; last_ar_cyc = -1;
      run_cmd(2'd2, 4'h0, 32'h0, 32'h1, 0, rd, re, rt, lat);
      chk_eq("poll_reads", 32'(ar_hs - a0), 32'd4);
      chk_eq("poll_gap", 32'(min_ar_gap >= int'(GAP)), 32'd1);
      chk_eq("poll_rsp", rd, 32'd0);
      chk_eq("poll_flags", 32'({re, rt}), 32'd0);

      // POLL with zero mask matches immediately
      poll_q.push_back(32'hDEAD_BEEF); a0 = ar_hs;
      run_cmd(2'd2, 4'h1, 32'h1234_5678, 32'h0, 0, rd, re, rt, lat);
      chk_eq("mask0_reads", 32'(ar_hs - a0), 32'd1);
      chk_eq("mask0_rsp", rd, 32'hDEAD_BEEF);
      chk_eq("mask0_err", 32'({re, rt}), 32'd0);

      // Reserved op: error response, no AXI traffic
      nv0 = any_valid_cyc;
      run_cmd(2'd3, 4'h2, 32'h0, 32'h0, 0, rd, re, rt, lat);
      chk_eq("rsv_lat", 32'(lat), 32'd1);
      chk_eq("rsv_err", 32'({re, rt}), 32'b10);
      chk_eq("rsv_novalid", 32'(any_valid_cyc - nv0), 32'd0);

      // POLL that never matches
      v = 32'h0000_00C3;
      run_cmd(2'd0, 4'h5, v, 32'h0, 0, rd, re, rt, lat);
      ref_mem[5] = v;
      a0 = ar_hs;
`ifdef AXIL_SEQ_POLL_TIMEOUT_EN
      run_cmd(2'd2, 4'h5, ~v, 32'hFFFF_FFFF, 0, rd, re, rt, lat);
      chk_eq("to_reads", 32'(ar_hs - a0), 32'(PMAX));
      chk_eq("to_flags", 32'({re, rt}), 32'b11);
      chk_eq("to_data", rd, v);
`else
      issue_cmd(2'd2, 4'h5, ~v, 32'hFFFF_FFFF);
      n = 0;
      while ((ar_hs - a0) <= 100 && !rsp_valid && n < 3000) begin @(negedge clk); n++; end
      chk_eq("endless_reads", 32'((ar_hs - a0) > 100), 32'd1);
      chk_eq("endless_norsp", 32'(rsp_valid), 32'd0);
      reset_dut();
`endif

      // Reset while waiting for B
      b_lat = 10;
      issue_cmd(2'd0, 4'h7, 32'h7777_7777, 32'h0);
      n = 0;
      while (!bready && n < 20) begin @(negedge clk); n++; end
      chk_eq("in_wr_resp", 32'(bready), 32'd1);
      reset_dut();
      b_lat = 0;

      // Randomized command mix against the reference model
      for (int t = 0; t < 40; t++) begin
         aw_lat = $urandom_range(0, 2); w_lat = $urandom_range(0, 2);
         ar_lat = $urandom_range(0, 2); b_lat = $urandom_range(0, 2);
         bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd0;
         rresp_cfg = ($urandom_range(0, 3) == 0) ? 2'd3 : 2'd0;
         op = 2'($urandom_range(0, 3));
         a = 4'($urandom);
         d = $urandom;
         m = ($urandom_range(0, 4) == 0) ? 32'h0 : (32'h1 << $urandom_range(0, 31)) | ($urandom & 32'h0F0F_0000);
         a0 = ar_hs; w0 = aw_hs; b0 = b_hs; nv0 = any_valid_cyc;
         min_ar_gap = 1000; last_ar_cyc = -1;
         exp_t = 0; nreads = 0;
         case (op)
            2'd0: begin exp_d = 0; exp_e = (bresp_cfg != 0); end
            2'd1: begin exp_d = ref_mem[a]; exp_e = (rresp_cfg != 0); nreads = 1; end
            2'd2: begin
               vals.delete();
               n = $urandom_range(0, PMAX - 1);
               for (int k = 0; k < n; k++) begin
                  v = $urandom;
                  if (((v ^ d) & m) == 0) v = v ^ (m & (~m + 32'd1));
                  vals.push_back(v);
               end
               vals.push_back((d & m) | ($urandom & ~m));
               poll_q = vals;
               poll_model(vals, d, m, rresp_cfg != 0, nreads, exp_d, exp_e, exp_t);
            end
            default: begin exp_d = 0; exp_e = 1; end
         endcase
         run_cmd(op, a, d, m, $urandom_range(0, 2), rd, re, rt, lat);
         chk_eq("rnd_data", rd, exp_d);
         chk_eq("rnd_flags", 32'({re, rt}), 32'({exp_e, exp_t}));
         chk_eq("rnd_reads", 32'(ar_hs - a0), 32'(nreads));
         if (op == 2'd0) begin
            ref_mem[a] = d;
            chk_eq("rnd_wr", {8'(aw_hs - w0), 8'(b_hs - b0), 12'(cap_awaddr), cap_wstrb},
                   {8'd1, 8'd1, 12'(a), 4'hF});
            chk_eq("rnd_wdata", cap_wdata, d);
         end else begin
            chk_eq("rnd_no_wr", 32'(aw_hs - w0), 32'd0);
         end
         if (op == 2'd2 && nreads > 1) chk_eq("rnd_gap", 32'(min_ar_gap >= int'(GAP)), 32'd1);
         if (op == 2'd3) chk_eq("rnd_rsv_novalid", 32'(any_valid_cyc - nv0), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
